// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC hit streamer: FSM state encoding and
// parameter-derived width helpers used by the top and its sub-module.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SEND = 2'd2
  } tdc_state_e;

  // Coarse counter width: whatever is left of the TOF word above the fine code.
  function automatic int tdc_cnt_w(input int tof_w, input int fine_w);
    return tof_w - fine_w;
  endfunction

  // Intensity width: enough bits to count every SPAD enable (0..spad_n).
  function automatic int tdc_int_w(input int spad_n);
    return $clog2(spad_n + 1);
  endfunction

  // Hit-count width: enough bits to hold 0..depth.
  function automatic int tdc_num_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Combinational population count of the SPAD enable vector; gives the
// per-hit intensity value stored alongside each TOF.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int SPAD_N = 16,
  parameter int INT_W  = tdc_int_w(SPAD_N)
) (
  input  logic [SPAD_N-1:0] spad,
  output logic [INT_W-1:0]  count
);

  logic [INT_W-1:0] sum_next;

  // Sum every enable bit into an INT_W-wide accumulator.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < SPAD_N; i++) begin
      sum_next = sum_next + INT_W'(spad[i]);
    end
  end

  assign count = sum_next;

endmodule

// File: rtl/tdc_hit_stream.sv
// TDC hit streamer: measures time-of-flight of SPAD hits within a frame,
// buffers up to DEPTH {tof, intensity} pairs and streams them out over an
// AXI-Stream style master once the frame closes.
//
// Build option: define TDC_DEAD_TIME_EN to enable the dead-time filter,
// which drops a hit whose tof is closer than MIN_GAP LSB after the
// previously accepted hit of the same frame. Without it every hit is kept
// until the buffer is full.
module tdc_hit_stream
  import tdc_pkg::*;
#(
  parameter int  TOF_W   = 15,
  parameter int  FINE_W  = 5,
  parameter int  DEPTH   = 4,
  parameter int  SPAD_N  = 16,
  parameter int  MIN_GAP = 4,
  localparam int CNT_W   = tdc_cnt_w(TOF_W, FINE_W),
  localparam int INT_W   = tdc_int_w(SPAD_N),
  localparam int NUM_W   = tdc_num_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [FINE_W-1:0] start_fine,
  input  logic [TOF_W-1:0]  range,
  input  logic              hit_valid,
  input  logic [FINE_W-1:0] hit_fine,
  input  logic [SPAD_N-1:0] hit_spad,
  output logic [TOF_W-1:0]  m_tdata,
  output logic [INT_W-1:0]  m_tint,
  output logic [NUM_W-1:0]  m_tnum,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              tdc_int,
  output logic              busy,
  output logic              ovf
);

`ifdef TDC_DEAD_TIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- state
  tdc_state_e         state_reg, state_next;
  logic [TOF_W-1:0]   range_reg;
  logic [FINE_W-1:0]  start_fine_reg;
  logic [CNT_W-1:0]   coarse_reg;
  logic [NUM_W-1:0]   hit_cnt_reg;
  logic               ovf_reg;
  logic               tdc_int_reg;
  logic [TOF_W-1:0]   prev_tof_reg;
  logic               has_prev_reg;

  logic [TOF_W-1:0]   slot_tof_reg [DEPTH];
  logic [INT_W-1:0]   slot_int_reg [DEPTH];

  logic [TOF_W-1:0]   m_tdata_reg;
  logic [INT_W-1:0]   m_tint_reg;
  logic [NUM_W-1:0]   m_tnum_reg;
  logic               m_tlast_reg;
  logic               m_tvalid_reg;
  logic [NUM_W-1:0]   rd_idx_reg;

  // ------------------------------------------------------- control terms
  logic acq_enter;
  logic acq_close;
  logic hs;
  logic last_hs;

  assign acq_enter = (state_reg == ST_IDLE) && frame_start;
  assign acq_close = (state_reg == ST_ACQ) &&
                     (coarse_reg == range_reg[TOF_W-1:FINE_W]);
  assign hs        = m_tvalid_reg && m_tready;
  assign last_hs   = hs && m_tlast_reg;

  // ------------------------------------------------------ tof calculation
  // The start reference carries one extra coarse tick: the start edge is
  // resolved one clock later than the stop edge.
  logic [TOF_W-1:0] minuend;
  logic [TOF_W-1:0] subtrahend;
  logic [TOF_W:0]   diff_wide;
  logic [TOF_W-1:0] tof_raw;
  logic [TOF_W-1:0] tof_val;
  logic [INT_W-1:0] hit_pop;

  assign minuend    = {coarse_reg, hit_fine};
  assign subtrahend = {CNT_W'(1), start_fine_reg};
  assign diff_wide  = {1'b0, minuend} - {1'b0, subtrahend};
  assign tof_raw    = diff_wide[TOF_W-1:0];
  // Borrow or out-of-window results are flagged with the all-ones code.
  assign tof_val    = (diff_wide[TOF_W] || (tof_raw > range_reg)) ? '1 : tof_raw;

  tdc_popcount #(
    .SPAD_N (SPAD_N),
    .INT_W  (INT_W)
  ) u_popcount (
    .spad  (hit_spad),
    .count (hit_pop)
  );

  // ------------------------------------------------------ hit acceptance
  logic hit_in_acq;
  logic slot_full;
  logic dead_drop;
  logic hit_take;
  logic hit_ovf;

  assign hit_in_acq = (state_reg == ST_ACQ) && hit_valid;
  assign slot_full  = (hit_cnt_reg == NUM_W'(DEPTH));
  // Widened compare so prev + gap cannot wrap past the all-ones code.
  assign dead_drop  = DEAD_EN && has_prev_reg &&
                      ({1'b0, tof_val} < ({1'b0, prev_tof_reg} + (TOF_W+1)'(MIN_GAP)));
  assign hit_take   = hit_in_acq && !dead_drop && !slot_full;
  assign hit_ovf    = hit_in_acq && !dead_drop && slot_full;

  // One-hot slot selects for the write pointer and the outgoing beat.
  logic [NUM_W-1:0] sel_idx;
  logic [DEPTH-1:0] wr_sel;
  logic [DEPTH-1:0] rd_sel;

  assign sel_idx = m_tvalid_reg ? (rd_idx_reg + NUM_W'(1)) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign wr_sel[gi] = (hit_cnt_reg == NUM_W'(gi));
      assign rd_sel[gi] = (sel_idx == NUM_W'(gi));
    end
  endgenerate

  // ----------------------------------------------------------------- FSM
  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (frame_start) state_next = ST_ACQ;
      ST_ACQ:  if (acq_close)   state_next = ST_SEND;
      ST_SEND: if (last_hs)     state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: latch frame parameters, run the coarse counter,
  // count accepted hits and track overflow / interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      range_reg      <= '0;
      start_fine_reg <= '0;
      coarse_reg     <= '0;
      hit_cnt_reg    <= '0;
      ovf_reg        <= 1'b0;
      tdc_int_reg    <= 1'b0;
    end else begin
      if (acq_enter) begin
        range_reg      <= range;
        start_fine_reg <= start_fine;
        coarse_reg     <= '0;
        hit_cnt_reg    <= '0;
        ovf_reg        <= 1'b0;
      end else if (state_reg == ST_ACQ) begin
        coarse_reg <= coarse_reg + CNT_W'(1);
        if (hit_take) hit_cnt_reg <= hit_cnt_reg + NUM_W'(1);
        if (hit_ovf)  ovf_reg     <= 1'b1;
      end
      if (acq_close) begin
        tdc_int_reg <= 1'b1;
      end else if (last_hs) begin
        tdc_int_reg <= 1'b0;
      end
    end
  end

  // Remember the last accepted tof for the dead-time filter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_tof_reg <= '0;
      has_prev_reg <= 1'b0;
    end else if (acq_enter) begin
      has_prev_reg <= 1'b0;
    end else if (hit_take) begin
      prev_tof_reg <= tof_val;
      has_prev_reg <= DEAD_EN;
    end
  end

  // Hit buffer: write the accepted hit into the slot at the current count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_tof_reg[i] <= '0;
        slot_int_reg[i] <= '0;
      end
    end else if (hit_take) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          slot_tof_reg[i] <= tof_val;
          slot_int_reg[i] <= hit_pop;
        end
      end
    end
  end

  // --------------------------------------------------------- stream out
  logic             load_beat;
  logic [TOF_W-1:0] beat_tof;
  logic [INT_W-1:0] beat_int;
  logic             beat_last;

  // A new beat is loaded on the first SEND cycle and after each
  // non-final handshake, so the stream has no bubbles.
  assign load_beat = (state_reg == ST_SEND) &&
                     (!m_tvalid_reg || (m_tready && !m_tlast_reg));

  // Select the slot feeding the next beat; an empty frame sends zeros.
  always_comb begin
    beat_tof  = '0;
    beat_int  = '0;
    beat_last = (hit_cnt_reg == '0) || ((sel_idx + NUM_W'(1)) == hit_cnt_reg);
    if (hit_cnt_reg != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_sel[i]) begin
          beat_tof = slot_tof_reg[i];
          beat_int = slot_int_reg[i];
        end
      end
    end
  end

  // Output beat registers: hold while stalled, advance on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_tdata_reg  <= '0;
      m_tint_reg   <= '0;
      m_tnum_reg   <= '0;
      m_tlast_reg  <= 1'b0;
      m_tvalid_reg <= 1'b0;
      rd_idx_reg   <= '0;
    end else if (load_beat) begin
      m_tdata_reg  <= beat_tof;
      m_tint_reg   <= beat_int;
      m_tnum_reg   <= hit_cnt_reg;
      m_tlast_reg  <= beat_last;
      m_tvalid_reg <= 1'b1;
      rd_idx_reg   <= sel_idx;
    end else if (last_hs) begin
      m_tlast_reg  <= 1'b0;
      m_tvalid_reg <= 1'b0;
    end
  end

  assign m_tdata  = m_tdata_reg;
  assign m_tint   = m_tint_reg;
  assign m_tnum   = m_tnum_reg;
  assign m_tlast  = m_tlast_reg;
  assign m_tvalid = m_tvalid_reg;
  assign tdc_int  = tdc_int_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign ovf      = ovf_reg;

endmodule
